// File: rtl/apb_slave_pkg.sv
// Shared state encoding, window geometry and address decode for the APB register bank.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } apb_state_e;

    localparam int unsigned NumWords   = 16;
    localparam int unsigned WinWidth   = 6;
    localparam int unsigned IdxWidth   = $clog2(NumWords);
    localparam logic [31:0] OowReadVal = 32'h0;

    // Window match ignores the word-index bits but insists on word alignment.
    function automatic logic addr_in_window(input logic [31:0] addr, input logic [31:0] base);
        return (addr[31:WinWidth] == base[31:WinWidth]) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// 16x32 register storage: one synchronous write port, one combinational read port.
module apb_slave_regfile
    import apb_slave_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_we,
    input  logic [IdxWidth-1:0] i_waddr,
    input  logic [31:0]         i_wdata,
    input  logic [IdxWidth-1:0] i_raddr,
    output logic [31:0]         o_rdata
);

    logic [31:0] r_mem [NumWords];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NumWords; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave_regbank.sv
// APB2 slave with a 16-word register window, protocol checking and sticky error reporting.
module apb_slave_regbank
    import apb_slave_pkg::*;
#(
    parameter int unsigned SEL_IDX   = 0,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        prot_err,
    output logic        addr_err,
    output logic [7:0]  err_count
);

    apb_state_e          r_state;
    logic [31:0]         r_addr;
    logic                r_write;

    logic                w_sel;
    logic                w_in_win;
    logic [IdxWidth-1:0] w_idx;
    logic [31:0]         w_rdata;
    logic                w_match;
    logic                w_access_ok;
    logic                w_viol;
    logic                w_we;

    assign w_sel    = |(Pselx & (3'b001 << SEL_IDX));
    assign w_in_win = addr_in_window(Paddr, BASE_ADDR);
    assign w_idx    = Paddr[2 +: IdxWidth];
    assign w_match  = (Paddr == r_addr) && (Pwrite == r_write);

    assign w_access_ok = w_sel && Penable && (r_state == StSetup) && w_match;
    // A second setup without an access, or any access not directly preceded by a matching setup.
    assign w_viol      = w_sel && ((!Penable && (r_state == StSetup)) ||
                                   (Penable && !((r_state == StSetup) && w_match)));
    assign w_we        = w_access_ok && r_write && w_in_win;

    apb_slave_regfile u_regfile (
        .i_clk   (Hclk),
        .i_rst_n (Hresetn),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (Pwdata),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state   <= StIdle;
            r_addr    <= '0;
            r_write   <= 1'b0;
            Prdata    <= '0;
            prot_err  <= 1'b0;
            addr_err  <= 1'b0;
            err_count <= '0;
        end else begin
            if (!w_sel) begin
                r_state <= StIdle;
            end else if (!Penable) begin
                r_state <= StSetup;
                r_addr  <= Paddr;
                r_write <= Pwrite;
                // Read data is fetched at setup so it is stable for the whole access cycle.
                if (!Pwrite) begin
                    Prdata <= w_in_win ? w_rdata : OowReadVal;
                    if (!w_in_win) begin
                        addr_err <= 1'b1;
                    end
                end
            end else if (w_access_ok) begin
                r_state <= StAccess;
                if (r_write && !w_in_win) begin
                    addr_err <= 1'b1;
                end
            end else begin
                r_state <= StIdle;
            end

            if (w_viol) begin
                prot_err <= 1'b1;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Self-checking bench for apb_slave_regbank: directed scenarios plus a randomized mix of transfers.
module tb_apb_slave_regbank;

    localparam logic [2:0]  SelMask = 3'b010;
    localparam logic [31:0] Base    = 32'h8000_0000;

    logic        Hclk;
    logic        Hresetn;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        prot_err;
    logic        addr_err;
    logic [7:0]  err_count;

    logic [31:0] exp_mem [16];
    bit          exp_prot;
    bit          exp_addr;
    int          exp_cnt;
    int          n_tests;
    int          n_fail;

    apb_slave_regbank #(
        .SEL_IDX   (1),
        .BASE_ADDR (Base)
    ) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata),
        .prot_err  (prot_err),
        .addr_err  (addr_err),
        .err_count (err_count)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic bit in_win(input logic [31:0] a);
        return (a >= Base) && (a < Base + 32'd64) && (a % 4 == 0);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - Base) / 4);
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned k = $urandom_range(0, 9);
        if (k <= 6)      return Base + 32'(4 * $urandom_range(0, 15));
        else if (k == 7) return Base + 32'($urandom_range(0, 63));
        else if (k == 8) return Base + 32'd64 + 32'(4 * $urandom_range(0, 15));
        else             return 32'($urandom);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) exp_mem[i] = '0;
        exp_prot = 0;
        exp_addr = 0;
        exp_cnt  = 0;
    endtask

    task automatic model_viol();
        exp_prot = 1;
        if (exp_cnt < 255) exp_cnt++;
    endtask

    task automatic model_xfer(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                              output logic [31:0] rd);
        rd = '0;
        if (!in_win(a)) exp_addr = 1;
        else if (wr)    exp_mem[widx(a)] = wd;
        else            rd = exp_mem[widx(a)];
    endtask

    task automatic bus_idle();
        Pselx   = 3'($urandom) & ~SelMask;
        Penable = 1'b0;
        Pwrite  = 1'($urandom);
        Paddr   = $urandom;
    endtask

    // Setup + access; leaves the bus in the access phase so a following call is back-to-back.
    task automatic xfer(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                        output logic [31:0] rd);
        Pselx   = SelMask | (3'($urandom) & ~SelMask);
        Penable = 1'b0;
        Paddr   = a;
        Pwrite  = wr;
        Pwdata  = wd;
        @(posedge Hclk); #1;
        rd      = Prdata;
        Penable = 1'b1;
        @(posedge Hclk); #1;
    endtask

    task automatic idle_cycle();
        bus_idle();
        @(posedge Hclk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd, er;
        Hresetn = 1'b0;
        bus_idle();
        Pwdata = '0;
        repeat (2) @(posedge Hclk);
        #1;
        n_tests++;
        if ({Prdata, prot_err, addr_err, err_count} !== 43'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%b/%b/%h, required 0/0/0/00",
                     Prdata, prot_err, addr_err, err_count);
        end
        Hresetn = 1'b1;
        model_reset();
        idle_cycle();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a = Base + 32'(4 * $urandom_range(0, 15));
            xfer(a, 1'b0, '0, rd);
            model_xfer(a, 1'b0, '0, er);
            n_tests++;
            if (rd !== er) begin
                n_fail++;
                $display("FAIL reset_mem_read: addr %h got %h, required %h", a, rd, er);
            end
            idle_cycle();
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd, er;
        xfer(32'h8000_0008, 1'b1, 32'hA5A5_0001, rd);
        model_xfer(32'h8000_0008, 1'b1, 32'hA5A5_0001, er);
        idle_cycle();
        xfer(32'h8000_0008, 1'b0, '0, rd);
        model_xfer(32'h8000_0008, 1'b0, '0, er);
        n_tests++;
        if (rd !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL write_read_data: got %h, required %h", rd, 32'hA5A5_0001);
        end
        idle_cycle();
        n_tests++;
        if ({prot_err, addr_err, err_count} !== 10'h0) begin
            n_fail++;
            $display("FAIL write_read_flags: got %b/%b/%h, required 0/0/00",
                     prot_err, addr_err, err_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, er;
        for (int i = 0; i < 4; i++) begin
            xfer(Base + 32'(4 * i), 1'b1, 32'(i + 1), rd);
            model_xfer(Base + 32'(4 * i), 1'b1, 32'(i + 1), er);
        end
        for (int i = 0; i < 4; i++) begin
            xfer(Base + 32'(4 * i), 1'b0, '0, rd);
            model_xfer(Base + 32'(4 * i), 1'b0, '0, er);
            n_tests++;
            if (rd !== 32'(i + 1)) begin
                n_fail++;
                $display("FAIL b2b_read[%0d]: got %h, required %h", i, rd, i + 1);
            end
        end
        idle_cycle();
        n_tests++;
        if ({prot_err, addr_err, err_count} !== 10'h0) begin
            n_fail++;
            $display("FAIL b2b_flags: got %b/%b/%h, required 0/0/00",
                     prot_err, addr_err, err_count);
        end
    endtask

    task automatic test_prot_violation();
        logic [31:0] rd, er;
        Pselx   = SelMask;
        Penable = 1'b1;
        Pwrite  = 1'b1;
        Paddr   = 32'h8000_0008;
        Pwdata  = 32'h1234_5678;
        @(posedge Hclk); #1;
        model_viol();
        idle_cycle();
        n_tests++;
        if ({prot_err, addr_err, err_count} !== {1'b1, 1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL prot_flags: got %b/%b/%h, required 1/0/01",
                     prot_err, addr_err, err_count);
        end
        xfer(32'h8000_0008, 1'b0, '0, rd);
        model_xfer(32'h8000_0008, 1'b0, '0, er);
        n_tests++;
        if (rd !== er) begin
            n_fail++;
            $display("FAIL prot_no_write: got %h, required %h", rd, er);
        end
        idle_cycle();
    endtask

    task automatic test_addr_err();
        logic [31:0] rd, er;
        xfer(32'h9000_0000, 1'b1, 32'hDEAD_BEEF, rd);
        model_xfer(32'h9000_0000, 1'b1, 32'hDEAD_BEEF, er);
        idle_cycle();
        n_tests++;
        if (addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oow_write_flag: got %b, required 1", addr_err);
        end
        xfer(32'h8000_0000, 1'b0, '0, rd);
        model_xfer(32'h8000_0000, 1'b0, '0, er);
        n_tests++;
        if (rd !== er) begin
            n_fail++;
            $display("FAIL oow_prior_value: got %h, required %h", rd, er);
        end
        xfer(32'h9000_0000, 1'b0, '0, rd);
        model_xfer(32'h9000_0000, 1'b0, '0, er);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL oow_read_zero: got %h, required 00000000", rd);
        end
        idle_cycle();
    endtask

    task automatic test_random();
        logic [31:0] rd, er, a, b, wd;
        for (int it = 0; it < 80; it++) begin
            int unsigned kind = $urandom_range(0, 5);
            a  = rand_addr();
            wd = $urandom;
            if (kind <= 1) begin
                xfer(a, 1'b1, wd, rd);
                model_xfer(a, 1'b1, wd, er);
            end else if (kind <= 3) begin
                xfer(a, 1'b0, '0, rd);
                model_xfer(a, 1'b0, '0, er);
                n_tests++;
                if (rd !== er) begin
                    n_fail++;
                    $display("FAIL rand_read[%0d]: addr %h got %h, required %h", it, a, rd, er);
                end
            end else if (kind == 4) begin
                // Address changes between setup and access: transfer is discarded.
                a = Base + 32'(4 * $urandom_range(0, 15));
                Pselx = SelMask; Penable = 1'b0; Paddr = a; Pwrite = 1'b1; Pwdata = wd;
                @(posedge Hclk); #1;
                Penable = 1'b1; Paddr = a ^ 32'h4;
                @(posedge Hclk); #1;
                model_viol();
            end else begin
                // Two setups in a row: second one is a violation but its access is honoured.
                b = rand_addr();
                Pselx = SelMask; Penable = 1'b0; Paddr = a; Pwrite = 1'b0;
                @(posedge Hclk); #1;
                model_xfer(a, 1'b0, '0, er);
                Paddr = b;
                @(posedge Hclk); #1;
                model_viol();
                model_xfer(b, 1'b0, '0, er);
                rd = Prdata;
                Penable = 1'b1;
                @(posedge Hclk); #1;
                n_tests++;
                if (rd !== er) begin
                    n_fail++;
                    $display("FAIL rand_dbl_setup[%0d]: addr %h got %h, required %h",
                             it, b, rd, er);
                end
            end
            if ($urandom_range(0, 1) == 0) idle_cycle();
            n_tests++;
            if ({prot_err, addr_err, err_count} !== {exp_prot, exp_addr, 8'(exp_cnt)}) begin
                n_fail++;
                $display("FAIL rand_flags[%0d]: got %b/%b/%h, required %b/%b/%h", it,
                         prot_err, addr_err, err_count, exp_prot, exp_addr, 8'(exp_cnt));
            end
        end
        idle_cycle();
    endtask

    task automatic test_saturation();
        Pselx   = SelMask;
        Penable = 1'b1;
        Pwrite  = 1'b0;
        Paddr   = Base;
        repeat (300) begin
            @(posedge Hclk);
            model_viol();
        end
        #1;
        idle_cycle();
        n_tests++;
        if ({prot_err, err_count} !== {exp_prot, 8'(exp_cnt)} || err_count !== 8'hFF) begin
            n_fail++;
            $display("FAIL saturation: got %b/%h, required 1/ff", prot_err, err_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, er;
        Pselx = SelMask; Penable = 1'b0; Paddr = 32'h8000_0004; Pwrite = 1'b1;
        Pwdata = 32'hCAFE_F00D;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        #2;
        Hresetn = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({Prdata, prot_err, addr_err, err_count} !== 43'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h/%b/%b/%h, required 0/0/0/00",
                     Prdata, prot_err, addr_err, err_count);
        end
        @(posedge Hclk); #1;
        Hresetn = 1'b1;
        // Bus still shows the access phase; the first edge after release sees it from idle.
        @(posedge Hclk); #1;
        model_viol();
        idle_cycle();
        n_tests++;
        if ({prot_err, addr_err, err_count} !== {exp_prot, exp_addr, 8'(exp_cnt)}) begin
            n_fail++;
            $display("FAIL reset_mid_flags: got %b/%b/%h, required %b/%b/%h",
                     prot_err, addr_err, err_count, exp_prot, exp_addr, 8'(exp_cnt));
        end
        xfer(32'h8000_0004, 1'b0, '0, rd);
        model_xfer(32'h8000_0004, 1'b0, '0, er);
        n_tests++;
        if (rd !== er) begin
            n_fail++;
            $display("FAIL reset_mid_no_write: got %h, required %h", rd, er);
        end
        idle_cycle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_prot_violation();
        test_addr_err();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
